// File: rtl/tempsens_uart_host.sv
// UART host for a temperature sensor: sends a request byte, then collects a
// two-byte little-endian reply with per-byte start-bit timeout and framing checks.
module tempsens_uart_host #(
  parameter int unsigned CLK_FREQ    = 10000,
  parameter int unsigned BAUD        = 1000,
  parameter logic [7:0]  CMD_REQ     = 8'h53,
  parameter int unsigned TIMEOUT_CYC = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic [15:0] data,
  output logic        valid,
  output logic        err
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam int unsigned CYC_W   = $clog2(BIT_CYC + 1);
  localparam int unsigned TOUT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BIT_W   = 4;
  localparam logic [9:0]  FRAME   = {1'b1, CMD_REQ, 1'b0};

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_CMD = 3'd1;
  localparam logic [2:0] WAIT_LO  = 3'd2;
  localparam logic [2:0] WAIT_HI  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state, state_n;
  logic              rx_s1, rx_s2, rx_d;
  logic [CYC_W-1:0]  cyc_cnt, cyc_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [TOUT_W-1:0] tout_cnt, tout_n;
  logic              rx_act, rx_act_n;
  logic [7:0]        shreg, shreg_n;
  logic [7:0]        lo, lo_n;
  logic              tx_n, busy_n, valid_n, err_n;
  logic [15:0]       data_n;

  logic rx_fall, cyc_last, cyc_mid;
  assign rx_fall  = rx_d & ~rx_s2;
  assign cyc_last = (cyc_cnt == CYC_W'(BIT_CYC - 1));
  assign cyc_mid  = (cyc_cnt == CYC_W'(BIT_CYC / 2));

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      tout_cnt <= '0;
      rx_act   <= 1'b0;
      shreg    <= '0;
      lo       <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      cyc_cnt  <= cyc_n;
      bit_cnt  <= bit_n;
      tout_cnt <= tout_n;
      rx_act   <= rx_act_n;
      shreg    <= shreg_n;
      lo       <= lo_n;
      tx       <= tx_n;
      busy     <= busy_n;
      data     <= data_n;
      valid    <= valid_n;
      err      <= err_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n  = state;
    cyc_n    = cyc_cnt;
    bit_n    = bit_cnt;
    tout_n   = tout_cnt;
    rx_act_n = rx_act;
    shreg_n  = shreg;
    lo_n     = lo;
    tx_n     = tx;
    data_n   = data;
    valid_n  = 1'b0;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        tx_n     = 1'b1;
        rx_act_n = 1'b0;
        if (start) begin
          state_n = SEND_CMD;
          tx_n    = FRAME[0];
          cyc_n   = '0;
          bit_n   = '0;
        end
      end
      SEND_CMD: begin
        if (cyc_last) begin
          cyc_n = '0;
          if (bit_cnt == BIT_W'(9)) begin
            state_n = WAIT_LO;
            tx_n    = 1'b1;
            tout_n  = '0;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
            tx_n  = FRAME[bit_cnt + BIT_W'(1)];
          end
        end else begin
          cyc_n = cyc_cnt + CYC_W'(1);
        end
      end
      WAIT_LO, WAIT_HI: begin
        if (!rx_act) begin
          // Timeout counts only while hunting for a start edge
          if (rx_fall) begin
            rx_act_n = 1'b1;
            cyc_n    = '0;
            bit_n    = '0;
          end else if (tout_cnt == TOUT_W'(TIMEOUT_CYC - 1)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            tout_n = tout_cnt + TOUT_W'(1);
          end
        end else begin
          cyc_n = cyc_last ? '0 : cyc_cnt + CYC_W'(1);
          if (cyc_last) bit_n = bit_cnt + BIT_W'(1);
          if (cyc_mid) begin
            if (bit_cnt == BIT_W'(0)) begin
              if (rx_s2) rx_act_n = 1'b0;
            end else if (bit_cnt != BIT_W'(9)) begin
              shreg_n = {rx_s2, shreg[7:1]};
            end else begin
              rx_act_n = 1'b0;
              if (!rx_s2) begin
                err_n   = 1'b1;
                state_n = IDLE;
              end else if (state == WAIT_LO) begin
                lo_n    = shreg;
                state_n = WAIT_HI;
                tout_n  = '0;
              end else begin
                state_n = DONE;
                data_n  = {shreg, lo};
                valid_n = 1'b1;
              end
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
